exec_mc: RTL

EXEC_MC -- requirements
Module: exec_mc

---
 rtl/swt16_exec_pkg.sv | 25 ++
 rtl/exec_mul_iter.sv | 60 ++++++
 rtl/exec_mc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/swt16_exec_pkg.sv
// Shared opcode encodings and exec FSM state type for the swt16 execute stage.
package swt16_exec_pkg;

   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'd1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'd2;
   localparam logic [OPC_W-1:0] OP_AND = 4'd3;
   localparam logic [OPC_W-1:0] OP_OR  = 4'd4;
   localparam logic [OPC_W-1:0] OP_XOR = 4'd5;
   localparam logic [OPC_W-1:0] OP_SHL = 4'd6;
   localparam logic [OPC_W-1:0] OP_SHR = 4'd7;
   localparam logic [OPC_W-1:0] OP_JMP = 4'd8;
   localparam logic [OPC_W-1:0] OP_BEQ = 4'd9;
   localparam logic [OPC_W-1:0] OP_BNE = 4'd10;
   localparam logic [OPC_W-1:0] OP_MUL = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } exec_state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
module exec_mul_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   // Load on start, then accumulate shifted multiplicand for each set multiplier bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            active  <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
         end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            mcand   <= op_a;
            mplier  <= op_b;
            product <= '0;
         end else if (active) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/exec_mc.sv
// Execute stage: single-cycle ALU/branch ops from an issue register, optional iterative MUL.
// Define EXEC_MC_MUL_EN to build the MUL FSM and multiplier; otherwise MUL is an unknown opcode.
module exec_mc
   import swt16_exec_pkg::*;
#(
   parameter int unsigned IALU_WORD_WIDTH = 16,
   parameter int unsigned PC_WIDTH        = 12,
   parameter int unsigned REG_IDX_WIDTH   = 4,
   parameter int unsigned OP_WIDTH        = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [OP_WIDTH-1:0]        in_op,
   input  logic [IALU_WORD_WIDTH-1:0] in_src1,
   input  logic [IALU_WORD_WIDTH-1:0] in_src2,
   input  logic [PC_WIDTH-1:0]        in_tgt,
   input  logic                       in_wr_en,
   input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
   input  logic                       in_kill,
   output logic                       out_stall,
   output logic                       out_valid,
   output logic [IALU_WORD_WIDTH-1:0] out_res,
   output logic                       out_wr_en,
   output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
   output logic                       out_set_pc,
   output logic                       out_flush,
   output logic [PC_WIDTH-1:0]        out_new_pc
);

   localparam int unsigned SH_W = $clog2(IALU_WORD_WIDTH);

   logic                       iss_valid;
   logic [OP_WIDTH-1:0]        iss_op;
   logic [IALU_WORD_WIDTH-1:0] iss_src1;
   logic [IALU_WORD_WIDTH-1:0] iss_src2;
   logic [PC_WIDTH-1:0]        iss_tgt;
   logic                       iss_wr_en;
   logic [REG_IDX_WIDTH-1:0]   iss_idx;

   logic                       accept_c;
   logic [IALU_WORD_WIDTH-1:0] sum_c;
   logic [IALU_WORD_WIDTH-1:0] res_c;
   logic [PC_WIDTH-1:0]        pc_c;
   logic                       wr_c;
   logic                       redir_c;
   logic                       ready_c;

   assign accept_c = in_valid & ~out_stall & ~in_kill;
   assign sum_c    = iss_src1 + iss_src2;

   // Issue register: load on accept, hold while stalled, otherwise retire after one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset || in_kill || (!accept_c && !out_stall)) begin
         iss_valid <= 1'b0;
         iss_op    <= '0;
         iss_src1  <= '0;
         iss_src2  <= '0;
         iss_tgt   <= '0;
         iss_wr_en <= 1'b0;
         iss_idx   <= '0;
      end else if (accept_c) begin
         iss_valid <= 1'b1;
         iss_op    <= in_op;
         iss_src1  <= in_src1;
         iss_src2  <= in_src2;
         iss_tgt   <= in_tgt;
         iss_wr_en <= in_wr_en;
         iss_idx   <= in_res_reg_idx;
      end
   end

`ifdef EXEC_MC_MUL_EN
   exec_state_t                state;
   exec_state_t                state_nxt;
   logic                       iss_is_mul_c;
   logic                       mul_start_c;
   logic                       mul_done;
   logic                       mul_ready_c;
   logic [IALU_WORD_WIDTH-1:0] mul_prod;

   assign iss_is_mul_c = iss_valid && (iss_op == OP_WIDTH'(OP_MUL));
   assign mul_start_c  = accept_c && (in_op == OP_WIDTH'(OP_MUL));

   exec_mul_iter #(
      .WIDTH (IALU_WORD_WIDTH)
   ) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (mul_start_c),
      .kill    (in_kill),
      .op_a    (in_src1),
      .op_b    (in_src2),
      .done    (mul_done),
      .product (mul_prod)
   );

   // MUL sequencing state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, stall and MUL-result-ready; kill always returns to IDLE.
   always_comb begin
      state_nxt   = state;
      out_stall   = 1'b0;
      mul_ready_c = 1'b0;
      case (state)
         ST_IDLE: begin
            out_stall = iss_is_mul_c;
            if (iss_is_mul_c) state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            out_stall = 1'b1;
            if (mul_done) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            mul_ready_c = 1'b1;
            state_nxt   = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (in_kill) state_nxt = ST_IDLE;
   end
`else
   assign out_stall = 1'b0;
`endif

   // Result/redirect decode from the issue register; everything is zero when not valid.
   always_comb begin
      res_c   = '0;
      pc_c    = '0;
      wr_c    = iss_wr_en;
      redir_c = 1'b0;
      ready_c = 1'b1;
      case (iss_op)
         OP_WIDTH'(OP_NOP): res_c = '0;
         OP_WIDTH'(OP_ADD): res_c = sum_c;
         OP_WIDTH'(OP_SUB): res_c = iss_src1 - iss_src2;
         OP_WIDTH'(OP_AND): res_c = iss_src1 & iss_src2;
         OP_WIDTH'(OP_OR):  res_c = iss_src1 | iss_src2;
         OP_WIDTH'(OP_XOR): res_c = iss_src1 ^ iss_src2;
         OP_WIDTH'(OP_SHL): res_c = iss_src1 << iss_src2[SH_W-1:0];
         OP_WIDTH'(OP_SHR): res_c = iss_src1 >> iss_src2[SH_W-1:0];
         OP_WIDTH'(OP_JMP): begin
            redir_c = 1'b1;
            pc_c    = sum_c[PC_WIDTH-1:0];
         end
         OP_WIDTH'(OP_BEQ): begin
            if (iss_src1 == iss_src2) begin
               redir_c = 1'b1;
               pc_c    = iss_tgt;
            end
         end
         OP_WIDTH'(OP_BNE): begin
            if (iss_src1 != iss_src2) begin
               redir_c = 1'b1;
               pc_c    = iss_tgt;
            end
         end
`ifdef EXEC_MC_MUL_EN
         OP_WIDTH'(OP_MUL): begin
            res_c   = mul_prod;
            ready_c = mul_ready_c;
         end
`endif
         default: wr_c = 1'b0;
      endcase
      out_valid       = iss_valid & ready_c & ~in_kill;
      out_res         = out_valid ? res_c : '0;
      out_wr_en       = out_valid & wr_c;
      out_res_reg_idx = out_valid ? iss_idx : '0;
      out_set_pc      = out_valid & redir_c;
      out_flush       = out_valid & redir_c;
      out_new_pc      = out_valid ? pc_c : '0;
   end

endmodule
